univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 151 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register (shift/rotate/load/clear) with
//               single-step and counted multi-step burst modes.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2:0]             op,
    input  logic [WIDTH-1:0]       d,
    input  logic [DEPTH*WIDTH-1:0] pd,
    input  logic                   start,
    input  logic [AW-1:0]          amt,
    output logic [DEPTH*WIDTH-1:0] q,
    output logic [WIDTH-1:0]       so,
    output logic                   busy,
    output logic                   done
);

    localparam int DW = DEPTH * WIDTH;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHR   = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_ROTL  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [AW-1:0]   cnt_q;
    logic [DW-1:0]   data_q;
    logic [WIDTH-1:0] so_q;
    logic            busy_q;
    logic            done_q;

    logic [2:0]      op_d;
    logic [DW-1:0]   data_d;
    logic [WIDTH-1:0] so_d;

    // The op applied this cycle: live input while idle, latched copy during a burst.
    always_comb begin
        op_d   = (state_q == S_RUN) ? op_q : op;
        data_d = data_q;
        so_d   = so_q;
        case (op_d)
            OP_HOLD: begin
                data_d = data_q;
            end
            OP_SHR: begin
                data_d = {d, data_q[DW-1:WIDTH]};
                so_d   = data_q[WIDTH-1:0];
            end
            OP_SHL: begin
                data_d = {data_q[DW-WIDTH-1:0], d};
                so_d   = data_q[DW-1 -: WIDTH];
            end
            OP_LOAD: begin
                data_d = pd;
            end
            OP_ROTR: begin
                data_d = {data_q[WIDTH-1:0], data_q[DW-1:WIDTH]};
                so_d   = data_q[WIDTH-1:0];
            end
            OP_ROTL: begin
                data_d = {data_q[DW-WIDTH-1:0], data_q[DW-1 -: WIDTH]};
                so_d   = data_q[DW-1 -: WIDTH];
            end
            OP_CLEAR: begin
                data_d = '0;
                so_d   = '0;
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            so_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        if (amt == '0) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            data_q <= data_d;
                            so_q   <= so_d;
                            cnt_q  <= amt - AW'(1);
                            if (amt == AW'(1)) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                                busy_q  <= 1'b1;
                            end
                        end
                    end else if (en) begin
                        data_q <= data_d;
                        so_q   <= so_d;
                    end
                end
                S_RUN: begin
                    data_q <= data_d;
                    so_q   <= so_d;
                    cnt_q  <= cnt_q - AW'(1);
                    // Last step of the burst: leave RUN as done rises.
                    if (cnt_q == AW'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = data_q;
    assign so   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int AWL = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             en, start;
    logic [2:0]       op;
    logic [AWL-1:0]   amt;
    logic [W-1:0]     d;
    logic [N*W-1:0]   pd;
    logic [N*W-1:0]   q;
    logic [W-1:0]     so;
    logic             busy, done;

    logic             en1, start1;
    logic [2:0]       op1;
    logic [AWL-1:0]   amt1;
    logic             d1;
    logic [N-1:0]     pd1;
    logic [N-1:0]     q1;
    logic             so1, busy1, done1;

    univ_shift_reg #(.WIDTH(W), .DEPTH(N)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .pd(pd),
        .start(start), .amt(amt), .q(q), .so(so), .busy(busy), .done(done)
    );

    univ_shift_reg #(.WIDTH(1), .DEPTH(N)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .op(op1), .d(d1), .pd(pd1),
        .start(start1), .amt(amt1), .q(q1), .so(so1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: array of stages plus a count of burst steps still owed.
    logic [W-1:0] m_st [N];
    logic [W-1:0] m_so;
    int           m_left;
    logic [2:0]   m_op;
    logic         m_done;

    function automatic logic [N*W-1:0] exp_q();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_st[i];
        return v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_st[i] = '0;
        m_so   = '0;
        m_left = 0;
        m_op   = 3'd0;
        m_done = 1'b0;
    endfunction

    function automatic void m_apply(input logic [2:0] o, input logic [W-1:0] dv,
                                    input logic [N*W-1:0] pv);
        logic [W-1:0] first, last;
        first = m_st[0];
        last  = m_st[N-1];
        case (o)
            3'd1: begin
                for (int i = 0; i < N-1; i++) m_st[i] = m_st[i+1];
                m_st[N-1] = dv; m_so = first;
            end
            3'd2: begin
                for (int i = N-1; i > 0; i--) m_st[i] = m_st[i-1];
                m_st[0] = dv; m_so = last;
            end
            3'd3: for (int i = 0; i < N; i++) m_st[i] = pv[i*W +: W];
            3'd4: begin
                for (int i = 0; i < N-1; i++) m_st[i] = m_st[i+1];
                m_st[N-1] = first; m_so = first;
            end
            3'd5: begin
                for (int i = N-1; i > 0; i--) m_st[i] = m_st[i-1];
                m_st[0] = last; m_so = last;
            end
            3'd6: begin
                for (int i = 0; i < N; i++) m_st[i] = '0;
                m_so = '0;
            end
            default: ;
        endcase
    endfunction

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_apply(m_op, d, pd);
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (start) begin
                m_op = op;
                if (amt == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_apply(op, d, pd);
                    m_left = int'(amt) - 1;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (en) begin
                m_apply(op, d, pd);
            end
        end
        #1;
    endtask

    task automatic load(input logic [N*W-1:0] v);
        en = 1'b1; op = 3'd3; pd = v; start = 1'b0;
        tick();
        en = 1'b0; op = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 0; start = 0; op = 0; amt = 0; d = 0; pd = 0;
        en1 = 0; start1 = 0; op1 = 0; amt1 = 0; d1 = 0; pd1 = 0;
        m_reset();
        #2;
        total++;
        if (q !== '0 || so !== '0) begin
            bad++; $display("FAIL reset_data: q=%h so=%h required 0/0", q, so);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || q1 !== '0) begin
            bad++; $display("FAIL reset_flags: busy=%b done=%b q1=%b required 0", busy, done, q1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_w1_shr();
        logic [3:0] mq;
        logic       mso;
        logic [3:0] seq;
        seq = 4'b1101;  // applied bit 0 first: 1,0,1,1
        mq = '0;
        en1 = 1'b1; op1 = 3'b001;
        for (int i = 0; i < 4; i++) begin
            d1 = seq[i];
            tick();
            mq = {d1, mq[3:1]};
            total++;
            if (so1 !== 1'b0) begin
                bad++; $display("FAIL w1_so_edge%0d: got %b required 0", i, so1);
            end
        end
        total++;
        if (q1 !== 4'b1101) begin
            bad++; $display("FAIL w1_q_seq: got %b required 1101", q1);
        end
        for (int i = 0; i < 16; i++) begin
            d1 = 1'($urandom);
            tick();
            mso = mq[0];
            mq = {d1, mq[3:1]};
            total++;
            if (q1 !== mq || so1 !== mso) begin
                bad++; $display("FAIL w1_shr_rand: q=%b so=%b required q=%b so=%b", q1, so1, mq, mso);
            end
        end
        en1 = 1'b0;
    endtask

    task automatic test_load_rotl();
        int nb, nd;
        load(32'h44332211);
        total++;
        if (q !== 32'h44332211) begin
            bad++; $display("FAIL load: got %h required 44332211", q);
        end
        start = 1'b1; op = 3'd5; amt = AWL'(4);
        nb = 0; nd = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            start = 1'b0; op = 3'd0; amt = '0;
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
        end
        total++;
        if (nb != 3 || nd != 1) begin
            bad++; $display("FAIL rotl_burst_flags: busy_cycles=%0d done_pulses=%0d required 3/1", nb, nd);
        end
        total++;
        if (q !== 32'h44332211) begin
            bad++; $display("FAIL rotl_burst_q: got %h required 44332211", q);
        end
    endtask

    task automatic test_shl_burst();
        load(32'h44332211);
        start = 1'b1; op = 3'd2; amt = AWL'(2); d = 8'hAA;
        tick();
        start = 1'b0; op = 3'd0; amt = '0;
        tick();
        total++;
        if (q !== 32'h2211AAAA || so !== 8'h33) begin
            bad++; $display("FAIL shl_burst: q=%h so=%h required 2211aaaa/33", q, so);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL shl_burst_done: done=%b busy=%b required 1/0", done, busy);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL shl_done_width: done=%b required 0", done);
        end
    endtask

    task automatic test_amt_zero_one();
        logic [N*W-1:0] saved;
        saved = {$urandom};
        load(saved);
        start = 1'b1; op = 3'd1; amt = '0; d = 8'h5C;
        tick();
        start = 1'b0;
        total++;
        if (q !== saved || busy !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL amt0: q=%h busy=%b done=%b required %h/0/1", q, busy, done, saved);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL amt0_done_width: done=%b required 0", done);
        end
        start = 1'b1; op = 3'd2; amt = AWL'(1); d = 8'($urandom);
        tick();
        start = 1'b0;
        total++;
        if (q !== {saved[N*W-W-1:0], d} || busy !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL amt1: q=%h busy=%b done=%b required %h/0/1", q, busy, done, {saved[N*W-W-1:0], d});
        end
        tick();
        total++;
        if (done !== 1'b0 || q !== exp_q()) begin
            bad++; $display("FAIL amt1_after: done=%b q=%h required 0/%h", done, q, exp_q());
        end
    endtask

    task automatic test_rot_identity();
        logic [N*W-1:0] saved;
        saved = {$urandom};
        load(saved);
        start = 1'b1; op = 3'd4; amt = AWL'(N);
        for (int i = 0; i < N; i++) begin
            tick();
            start = 1'b0; op = 3'd0; amt = '0;
        end
        total++;
        if (q !== saved || done !== 1'b1) begin
            bad++; $display("FAIL rotr_identity: q=%h done=%b required %h/1", q, done, saved);
        end
    endtask

    task automatic test_rst_midburst();
        bit seen_done;
        load({$urandom});
        start = 1'b1; op = 3'd1; amt = AWL'(5); d = 8'($urandom);
        tick();
        start = 1'b0; op = 3'd0; amt = '0;
        tick();
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        total++;
        if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || so !== '0) begin
            bad++; $display("FAIL rst_midburst: q=%h busy=%b done=%b so=%h required all 0", q, busy, done, so);
        end
        tick();
        rst = 1'b0;
        start = 1'b1; op = 3'd2; amt = AWL'(3); d = 8'($urandom);
        tick();
        start = 1'b0; op = 3'd0; amt = '0;
        total++;
        if (busy !== 1'b1 || q !== exp_q()) begin
            bad++; $display("FAIL start_after_rst: busy=%b q=%h required 1/%h", busy, q, exp_q());
        end
        seen_done = 0;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            tick();
            if (done === 1'b1) seen_done = 1;
        end
        total++;
        if (!seen_done || q !== exp_q() || so !== m_so) begin
            bad++; $display("FAIL burst_after_rst: done_seen=%0d q=%h so=%h required 1/%h/%h", seen_done, q, so, exp_q(), m_so);
        end
    endtask

    task automatic test_back_to_back();
        int b2b;
        b2b = 0;
        load({$urandom});
        start = 1'b1; op = 3'($urandom_range(1, 6)); amt = AWL'($urandom_range(2, 7));
        for (int c = 0; c < 300; c++) begin
            tick();
            total++;
            if (q !== exp_q() || so !== m_so || busy !== (m_left > 0) || done !== m_done) begin
                bad++;
                $display("FAIL b2b_cycle%0d: q=%h so=%h busy=%b done=%b required %h/%h/%b/%b",
                         c, q, so, busy, done, exp_q(), m_so, (m_left > 0), m_done);
            end
            d  = 8'($urandom);
            pd = {$urandom};
            if (m_left > 0) begin
                en = 1'($urandom); start = 1'($urandom);
                op = 3'($urandom); amt = AWL'($urandom);
            end else if (m_done) begin
                b2b++;
                en = 1'($urandom); start = 1'b1;
                op = 3'($urandom_range(1, 6)); amt = AWL'($urandom_range(0, 7));
            end else begin
                en = 1'($urandom); start = ($urandom_range(0, 3) == 0);
                op = 3'($urandom); amt = AWL'($urandom);
            end
        end
        en = 1'b0; start = 1'b0;
        total++;
        if (b2b < 5) begin
            bad++; $display("FAIL b2b_count: got %0d back-to-back starts required >=5", b2b);
        end
    endtask

    initial begin
        test_reset();
        test_w1_shr();
        test_load_rotl();
        test_shl_burst();
        test_amt_zero_one();
        test_rot_identity();
        test_rst_midburst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
